matrix_loader: RTL

Stream sink directly downstream of the matrix file reader. Starts the reader and accepts its (i, j, value) stream on a strobe/acknowledge handshake. Stores all n×n 32-bit words in a local buffer, then serves single-cycle-latency random-access reads to the multiplier core. One instance per operand matrix.

---
 rtl/mm_pkg.sv | 19 +
 rtl/matrix_buf.sv | 47 ++++
 rtl/matrix_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: definitions shared by the matrix reader, the loader and the multiplier core.
//   state_t  - loader FSM states (S_IDLE, S_LOAD, S_READY)
//   DATA_W   - matrix element width in bits
//   idx_w(n) - width of a row/column index for an n x n matrix
package mm_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_buf.sv
// matrix_buf: N x N array of DATA_W-bit words, one synchronous write port and
// one registered read port.
//   clk, rst              clock, asynchronous active-high reset (read register only)
//   we_i                  write enable
//   wr_row_i, wr_col_i    write address
//   wr_data_i             write data
//   rd_row_i, rd_col_i    read address, sampled every cycle
//   rd_data_o             data at the read address, one cycle later
// A read and a write to the same location in one cycle return the old word.
module matrix_buf
    import mm_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IW-1:0]     wr_row_i,
    input  logic [IW-1:0]     wr_col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IW-1:0]     rd_row_i,
    input  logic [IW-1:0]     rd_col_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [N][N];
    logic [DATA_W-1:0] rd_data_q;

    // Storage itself is never cleared, so it carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_row_i][rd_col_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: stream sink behind the matrix file reader. Starts the reader,
// takes its (i, j, value) words on an in_stb/in_ack handshake, stores the
// n x n matrix in matrix_buf and then serves registered random-access reads.
//   clk, rst             clock, asynchronous active-high reset
//   load                 one-cycle request to (re)load the buffer
//   rd_start             one-cycle start pulse to the reader
//   in_i, in_j, in_value word from the reader, valid while in_stb is high
//   in_ack               one-cycle acknowledge per accepted word
//   rd_done              reader has nothing more to send
//   busy, ready          load in progress / buffer complete and readable
//   order_err            sticky: stream out of row-major order, or short
//   addr_row, addr_col   read address
//   rd_data              buffer[addr_row][addr_col], one cycle later
// Build option LOADER_TRANSPOSE_EN: when defined, words are stored at
// [in_j][in_i] so the buffer holds the transpose; the order check still
// expects row-major input.
module matrix_loader
    import mm_pkg::*;
#(
    parameter  int n  = 8,
    localparam int IW = idx_w(n)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    output logic              rd_start,
    input  logic [IW-1:0]     in_i,
    input  logic [IW-1:0]     in_j,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_stb,
    output logic              in_ack,
    input  logic              rd_done,
    output logic              busy,
    output logic              ready,
    output logic              order_err,
    input  logic [IW-1:0]     addr_row,
    input  logic [IW-1:0]     addr_col,
    output logic [DATA_W-1:0] rd_data
);

    localparam int             CNT_W    = $clog2(n*n + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n*n - 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(n - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IW-1:0]    exp_i_q, exp_i_d;
    logic [IW-1:0]    exp_j_q, exp_j_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic             start_q, start_d;
    logic             armed_q, armed_d;
    logic             accept;
    logic [IW-1:0]    wr_row, wr_col;

    // A word is taken only on a fresh strobe: in_stb must have been seen low
    // since the previous accept (armed_q). A reader that keeps in_stb high
    // past in_ack therefore cannot get one element written or counted twice.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        exp_i_d = exp_i_q;
        exp_j_d = exp_j_q;
        err_d   = err_q;
        armed_d = armed_q;
        ack_d   = 1'b0;
        start_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (load) begin
                    start_d = 1'b1;
                    count_d = '0;
                    exp_i_d = '0;
                    exp_j_d = '0;
                    err_d   = 1'b0;
                    armed_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!in_stb) begin
                    armed_d = 1'b1;
                end
                if (in_stb && !ack_q && armed_q) begin
                    accept  = 1'b1;
                    ack_d   = 1'b1;
                    armed_d = 1'b0;
                    count_d = count_q + 1'b1;
                    if (in_i != exp_i_q || in_j != exp_j_q) begin
                        err_d = 1'b1;
                    end
                    // Explicit compare against n-1 so non-power-of-two n wraps correctly.
                    if (exp_j_q == LAST_IDX) begin
                        exp_j_d = '0;
                        exp_i_d = (exp_i_q == LAST_IDX) ? '0 : exp_i_q + 1'b1;
                    end else begin
                        exp_j_d = exp_j_q + 1'b1;
                    end
                    if (count_q == LAST_CNT) begin
                        state_d = S_READY;
                    end
                end else if (rd_done && !ack_q) begin
                    // Reader finished before n*n words arrived.
                    err_d   = 1'b1;
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            exp_i_q <= '0;
            exp_j_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            exp_i_q <= exp_i_d;
            exp_j_q <= exp_j_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            armed_q <= armed_d;
        end
    end

`ifdef LOADER_TRANSPOSE_EN
    assign wr_row = in_j;
    assign wr_col = in_i;
`else
    assign wr_row = in_i;
    assign wr_col = in_j;
`endif

    matrix_buf #(.N(n)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (accept),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col),
        .wr_data_i (in_value),
        .rd_row_i  (addr_row),
        .rd_col_i  (addr_col),
        .rd_data_o (rd_data)
    );

    assign rd_start  = start_q;
    assign in_ack    = ack_q;
    assign busy      = (state_q == S_LOAD);
    assign ready     = (state_q == S_READY);
    assign order_err = err_q;

endmodule
